// File: rtl/jstk_poll_ctrl.sv
// Purpose: periodic 5-byte poll sequencer for the PmodJSTK SPI joystick, unpacks X/Y/buttons.
// Latency: sample outputs update 2 CLK edges after SS is first sampled high; request 1 edge after tick.
// Backpressure: ticks arriving outside IDLE or while disabled are dropped; a stuck transfer aborts on timeout.
module jstk_poll_ctrl #(
    parameter int POLL_DIV    = 100000,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        enable,
    input  logic [1:0]  led_cmd,
    input  logic        clr_err,
    input  logic        jstk_ss,
    input  logic [39:0] jstk_dout,
    output logic        jstk_sndRec,
    output logic [7:0]  jstk_din,
    output logic [9:0]  x_pos,
    output logic [9:0]  y_pos,
    output logic [2:0]  btn,
    output logic        sample_valid,
    output logic        busy,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_BUSY = 2'd2
    } state_t;

    localparam logic [23:0] POLL_LAST = 24'(POLL_DIV - 1);
    localparam logic [31:0] TO_LAST   = 32'(TIMEOUT_CYC - 1);

    state_t      state;
    state_t      state_next;
    logic [23:0] poll_cnt;
    logic [31:0] to_cnt;
    logic        ss_s1;
    logic        ss_s2;
    logic        tick;
    logic        to_hit;
    logic        start_req;
    logic        done;
    logic        abort;

    // Only the fields that carry joystick data are consumed from the shift register.
    logic dout_unused;
    assign dout_unused = ^{jstk_dout[31:26], jstk_dout[15:10], jstk_dout[7:3]};

    assign tick   = (poll_cnt == POLL_LAST);
    assign to_hit = (to_cnt == TO_LAST);

    // Free-running poll period counter, independent of the transfer state.
    always_ff @(posedge CLK) begin
        if (RST) begin
            poll_cnt <= '0;
        end else if (tick) begin
            poll_cnt <= '0;
        end else begin
            poll_cnt <= poll_cnt + 24'd1;
        end
    end

    // Two-flop synchronizer for SS, which comes from the slow SPI clock domain.
    always_ff @(posedge CLK) begin
        if (RST) begin
            ss_s1 <= 1'b1;
            ss_s2 <= 1'b1;
        end else begin
            ss_s1 <= jstk_ss;
            ss_s2 <= ss_s1;
        end
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state <= S_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic; an SS edge always takes priority over the timeout.
    always_comb begin
        state_next = state;
        case (state)
            S_IDLE: begin
                if (tick && enable) begin
                    state_next = S_REQ;
                end
            end
            S_REQ: begin
                if (!ss_s2) begin
                    state_next = S_BUSY;
                end else if (to_hit) begin
                    state_next = S_IDLE;
                end
            end
            S_BUSY: begin
                if (ss_s2 || to_hit) begin
                    state_next = S_IDLE;
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Transition strobes driving the registered outputs.
    always_comb begin
        start_req = (state == S_IDLE) && (state_next == S_REQ);
        done      = (state == S_BUSY) && ss_s2;
        abort     = ((state == S_REQ) && ss_s2 && to_hit) ||
                    ((state == S_BUSY) && !ss_s2 && to_hit);
    end

    // Registered outputs, sample capture, error flag and per-state timeout counter.
    always_ff @(posedge CLK) begin
        if (RST) begin
            jstk_sndRec  <= 1'b0;
            jstk_din     <= 8'h80;
            x_pos        <= '0;
            y_pos        <= '0;
            btn          <= '0;
            sample_valid <= 1'b0;
            busy         <= 1'b0;
            timeout_err  <= 1'b0;
            to_cnt       <= '0;
        end else begin
            // sndRec stays high through REQ so the slow SPI engine cannot miss it.
            jstk_sndRec  <= (state_next == S_REQ);
            busy         <= (state_next == S_REQ) || (state_next == S_BUSY);
            sample_valid <= done;
            if (start_req) begin
                jstk_din <= {6'b100000, led_cmd};
            end
            if (done) begin
                x_pos <= {jstk_dout[25:24], jstk_dout[39:32]};
                y_pos <= {jstk_dout[9:8], jstk_dout[23:16]};
                btn   <= jstk_dout[2:0];
            end
            // A new timeout wins over a simultaneous clear so no abort goes unseen.
            if (abort) begin
                timeout_err <= 1'b1;
            end else if (clr_err) begin
                timeout_err <= 1'b0;
            end
            if (state_next != state) begin
                to_cnt <= '0;
            end else if (state != S_IDLE) begin
                to_cnt <= to_cnt + 32'd1;
            end
        end
    end

endmodule
